// File: rtl/fpu_issue_if.sv
// fpu_issue_if: decode request, unit start/done and writeback bus of the FPU issue controller
// Ports (slave = controller side):
//   req_*      decode offer, req_ready back to decode
//   issue_*    one-hot unit start pulses
//   div_done   iterative unit completion, div_abort cancels it
//   wb_*       register-file writeback port and selected unit
interface fpu_issue_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_class;
    logic [4:0] req_rd;
    logic [4:0] req_rs1;
    logic [4:0] req_rs2;
    logic       req_rd_f;
    logic       req_rs1_f;
    logic       req_rs2_f;
    logic       req_use_rs2;
    logic [3:0] req_tag;
    logic       issue_fast;
    logic       issue_add;
    logic       issue_mul;
    logic       issue_div;
    logic       div_done;
    logic       div_abort;
    logic       wb_valid;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;
    logic       wb_f;
    logic [3:0] wb_tag;
    modport master (
        output req_valid, req_class, req_rd, req_rs1, req_rs2, req_rd_f, req_rs1_f, req_rs2_f,
               req_use_rs2, req_tag, div_done,
        input  req_ready, issue_fast, issue_add, issue_mul, issue_div, div_abort,
               wb_valid, wb_sel, wb_rd, wb_f, wb_tag
    );
    modport slave (
        input  req_valid, req_class, req_rd, req_rs1, req_rs2, req_rd_f, req_rs1_f, req_rs2_f,
               req_use_rs2, req_tag, div_done,
        output req_ready, issue_fast, issue_add, issue_mul, issue_div, div_abort,
               wb_valid, wb_sel, wb_rd, wb_f, wb_tag
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: FPU hazard-checked issue and single-port writeback scheduler
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_flush    cancel all in-flight work
//   o_busy     any op pending, reserved or in the divider
//   bus        fpu_issue_if.slave: decode request, unit starts, div done/abort, writeback
module fpu_issue_ctrl #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    output logic        o_busy,
    fpu_issue_if.slave  bus
);
    localparam logic [1:0] C_FAST = 2'd0;
    localparam logic [1:0] C_ADD  = 2'd1;
    localparam logic [1:0] C_MUL  = 2'd2;
    localparam logic [1:0] C_DIV  = 2'd3;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_HOLD} div_state_t;
    typedef struct packed {
        logic       valid;
        logic [1:0] cls;
        logic [4:0] rd;
        logic       f;
        logic [3:0] tag;
    } rsv_t;
    div_state_t  r_state, w_state_nxt;
    rsv_t        r_rsv [8];
    logic [63:0] r_pend, w_pend_nxt;
    logic [4:0]  r_div_rd;
    logic        r_div_f;
    logic [3:0]  r_div_tag;
    logic [2:0]  w_lat;
    logic        w_hazard, w_accept, w_div_wb, w_wb, w_rsv_any;
    // Pending bits are indexed {file, reg}: int regs 0..31, FP regs 32..63; int x0 is never set.
    assign w_lat = bus.req_class == C_FAST ? 3'd1 :
                   bus.req_class == C_ADD  ? 3'(ADD_LAT) :
                   bus.req_class == C_MUL  ? 3'(MUL_LAT) : 3'd0;
    // Slot check looks at entry L now, because it shifts down to L-1 on the accept edge.
    assign w_hazard = r_pend[{bus.req_rs1_f, bus.req_rs1}] ||
                      (bus.req_use_rs2 && r_pend[{bus.req_rs2_f, bus.req_rs2}]) ||
                      r_pend[{bus.req_rd_f, bus.req_rd}] ||
                      (bus.req_class == C_DIV ? r_state != DIV_IDLE : r_rsv[w_lat].valid);
    assign bus.req_ready  = !rst && !i_flush && r_state != DIV_HOLD && !w_hazard;
    assign w_accept       = bus.req_valid && bus.req_ready;
    assign bus.issue_fast = w_accept && bus.req_class == C_FAST;
    assign bus.issue_add  = w_accept && bus.req_class == C_ADD;
    assign bus.issue_mul  = w_accept && bus.req_class == C_MUL;
    assign bus.issue_div  = w_accept && bus.req_class == C_DIV;
    assign bus.div_abort  = i_flush && !rst && r_state == DIV_RUN;
    // Fixed-latency entries own the port; the divider result fills an empty entry-0 cycle,
    // including the very cycle div_done arrives.
    assign w_div_wb = !r_rsv[0].valid && (r_state == DIV_HOLD || (r_state == DIV_RUN && bus.div_done));
    assign w_wb     = !rst && !i_flush && (r_rsv[0].valid || w_div_wb);
    assign bus.wb_valid = w_wb;
    assign bus.wb_sel   = !w_wb ? 2'd0 : r_rsv[0].valid ? r_rsv[0].cls : C_DIV;
    assign bus.wb_rd    = !w_wb ? 5'd0 : r_rsv[0].valid ? r_rsv[0].rd  : r_div_rd;
    assign bus.wb_f     = w_wb && (r_rsv[0].valid ? r_rsv[0].f : r_div_f);
    assign bus.wb_tag   = !w_wb ? 4'd0 : r_rsv[0].valid ? r_rsv[0].tag : r_div_tag;
    always_comb begin
        w_rsv_any = 1'b0;
        for (int i = 0; i < 8; i++) w_rsv_any = w_rsv_any | r_rsv[i].valid;
    end
    assign o_busy = |r_pend || w_rsv_any || r_state != DIV_IDLE;
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wb) w_pend_nxt[{bus.wb_f, bus.wb_rd}] = 1'b0;
        if (w_accept && {bus.req_rd_f, bus.req_rd} != 6'd0) w_pend_nxt[{bus.req_rd_f, bus.req_rd}] = 1'b1;
    end
    always_comb begin
        w_state_nxt = r_state == DIV_IDLE && bus.issue_div ? DIV_RUN :
                      r_state == DIV_RUN && bus.div_done ? (w_div_wb ? DIV_IDLE : DIV_HOLD) :
                      r_state == DIV_HOLD && w_div_wb ? DIV_IDLE : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state <= DIV_IDLE;
            r_pend  <= '0;
            for (int i = 0; i < 8; i++) r_rsv[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            for (int i = 0; i < 7; i++) r_rsv[i] <= r_rsv[i+1];
            r_rsv[7] <= '0;
            if (w_accept && bus.req_class != C_DIV)
                r_rsv[w_lat - 3'd1] <= {1'b1, bus.req_class, bus.req_rd, bus.req_rd_f, bus.req_tag};
        end
    end
    always_ff @(posedge clk) begin
        if (bus.issue_div) begin
            r_div_rd  <= bus.req_rd;
            r_div_f   <= bus.req_rd_f;
            r_div_tag <= bus.req_tag;
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed cycle-by-cycle checks of issue hazards, slot stalls, div hold and flush
module tb_fpu_issue_ctrl;
    localparam logic [1:0] FAST = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DIV  = 2'd3;
    logic clk = 1'b0;
    logic rst, flush, busy;
    int n_tot = 0;
    int n_bad = 0;
    fpu_issue_if bus();
    fpu_issue_ctrl #(.ADD_LAT(2), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .i_flush(flush), .o_busy(busy), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic iss(input string tag, input logic rdy, input logic [3:0] v);
        chk(tag, {27'd0, bus.req_ready, bus.issue_fast, bus.issue_add, bus.issue_mul, bus.issue_div}, {27'd0, rdy, v});
    endtask
    task automatic wbc(input string tag, input logic v, input logic [1:0] s, input logic f, input logic [4:0] rd, input logic [3:0] tg);
        chk(tag, {19'd0, bus.wb_valid, bus.wb_sel, bus.wb_f, bus.wb_rd, bus.wb_tag}, {19'd0, v, s, f, rd, tg});
    endtask
    task automatic req(input logic [1:0] c, input logic f, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u2, input logic [4:0] rs2, input logic [3:0] tg);
        bus.req_valid = 1'b1; bus.req_class = c; bus.req_rd = rd; bus.req_rd_f = f;
        bus.req_rs1 = rs1; bus.req_rs1_f = f; bus.req_rs2 = rs2; bus.req_rs2_f = f;
        bus.req_use_rs2 = u2; bus.req_tag = tg;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.div_done = 1'b0; flush = 1'b0; rst = 1'b0;
        #1;
    endtask
    initial begin
        rst = 1'b1; flush = 1'b0; bus.div_done = 1'b0;
        req(FAST, 1, 1, 10, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        iss("rst_rdy", 0, 4'b0000);
        wbc("rst_wb", 0, 0, 0, 0, 0);
        chk("rst_abort", {31'd0, bus.div_abort}, 0);
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        wbc("rst_wb2", 0, 0, 0, 0, 0);
        // independent FAST, ADD, MUL back to back
        tick(); req(FAST, 1, 1, 10, 0, 0, 1);  iss("a0", 1, 4'b1000); wbc("a0_wb", 0, 0, 0, 0, 0);
        tick(); req(ADD, 1, 2, 11, 1, 12, 2);  iss("a1", 1, 4'b0100); wbc("a1_wb", 1, FAST, 1, 1, 1);
        tick(); req(MUL, 1, 3, 13, 1, 14, 3);  iss("a2", 1, 4'b0010); wbc("a2_wb", 0, 0, 0, 0, 0);
        tick(); wbc("a3_wb", 1, ADD, 1, 2, 2);
        tick(); wbc("a4_wb", 1, MUL, 1, 3, 3);
        tick(); chk("a5_busy", {31'd0, busy}, 0);
        // RAW on f1, no bypass
        tick(); req(ADD, 1, 1, 10, 1, 11, 4);  iss("b0", 1, 4'b0100);
        tick(); req(FAST, 1, 4, 1, 0, 0, 5);   iss("b1", 0, 4'b0000);
        tick(); req(FAST, 1, 4, 1, 0, 0, 5);   iss("b2", 0, 4'b0000); wbc("b2_wb", 1, ADD, 1, 1, 4);
        tick(); req(FAST, 1, 4, 1, 0, 0, 5);   iss("b3", 1, 4'b1000); wbc("b3_wb", 0, 0, 0, 0, 0);
        tick(); wbc("b4_wb", 1, FAST, 1, 4, 5);
        tick();
        // writeback slot collision
        tick(); req(ADD, 1, 6, 10, 0, 0, 6);   iss("c0", 1, 4'b0100);
        tick(); req(FAST, 1, 7, 12, 0, 0, 7);  iss("c1", 0, 4'b0000);
        tick(); req(FAST, 1, 7, 12, 0, 0, 7);  iss("c2", 1, 4'b1000); wbc("c2_wb", 1, ADD, 1, 6, 6);
        tick(); wbc("c3_wb", 1, FAST, 1, 7, 7);
        tick();
        // divide with writeback held behind a MUL, second divide blocked until idle
        tick(); req(DIV, 1, 5, 20, 0, 0, 8);   iss("d0", 1, 4'b0001);
        tick(); req(DIV, 1, 9, 21, 0, 0, 9);   iss("d1", 0, 4'b0000); chk("d1_busy", {31'd0, busy}, 1);
        tick(); req(FAST, 1, 13, 20, 0, 0, 10); iss("d2", 1, 4'b1000);
        tick(); wbc("d3_wb", 1, FAST, 1, 13, 10);
        tick(); req(DIV, 1, 9, 21, 0, 0, 9);   iss("d4", 0, 4'b0000);
        tick(); tick(); tick();
        tick(); req(MUL, 1, 8, 21, 1, 22, 11); iss("d8", 1, 4'b0010);
        tick(); req(DIV, 1, 9, 21, 0, 0, 9);   iss("d9", 0, 4'b0000);
        tick(); bus.div_done = 1'b1; req(DIV, 1, 9, 21, 0, 0, 9);
        iss("d10", 0, 4'b0000); wbc("d10_wb", 1, MUL, 1, 8, 11);
        tick(); req(DIV, 1, 9, 21, 0, 0, 9);   iss("d11", 0, 4'b0000); wbc("d11_wb", 1, DIV, 1, 5, 8);
        tick(); req(DIV, 1, 9, 21, 0, 0, 9);   iss("d12", 1, 4'b0001); wbc("d12_wb", 0, 0, 0, 0, 0);
        tick(); wbc("d13_wb", 0, 0, 0, 0, 0);
        tick(); bus.div_done = 1'b1; #1;      wbc("d14_wb", 1, DIV, 1, 9, 9);
        tick(); wbc("d15_wb", 0, 0, 0, 0, 0); chk("d15_busy", {31'd0, busy}, 0);
        // flush during divide with ADD in flight
        tick(); req(DIV, 1, 5, 20, 0, 0, 12);  iss("f0", 1, 4'b0001);
        tick(); req(ADD, 1, 2, 21, 0, 0, 13);  iss("f1", 1, 4'b0100);
        tick(); flush = 1'b1; req(FAST, 1, 3, 22, 0, 0, 14);
        iss("f2", 0, 4'b0000); chk("f2_abort", {31'd0, bus.div_abort}, 1); wbc("f2_wb", 0, 0, 0, 0, 0);
        tick(); wbc("f3_wb", 0, 0, 0, 0, 0); chk("f3_busy", {31'd0, busy}, 0); chk("f3_abort", {31'd0, bus.div_abort}, 0);
        tick(); bus.div_done = 1'b1; #1;      wbc("f4_wb", 0, 0, 0, 0, 0);
        tick(); req(FAST, 1, 3, 2, 0, 0, 14);  iss("f5", 1, 4'b1000);
        tick(); wbc("f6_wb", 1, FAST, 1, 3, 14);
        tick();
        // reset mid-run
        tick(); req(DIV, 1, 5, 20, 0, 0, 15);  iss("g0", 1, 4'b0001);
        tick(); req(ADD, 1, 2, 21, 0, 0, 13);  iss("g1", 1, 4'b0100);
        tick(); rst = 1'b1; req(FAST, 1, 3, 22, 0, 0, 14);
        iss("g2", 0, 4'b0000); chk("g2_abort", {31'd0, bus.div_abort}, 0); wbc("g2_wb", 0, 0, 0, 0, 0);
        tick(); wbc("g3_wb", 0, 0, 0, 0, 0); chk("g3_busy", {31'd0, busy}, 0);
        tick(); bus.div_done = 1'b1; #1;      wbc("g4_wb", 0, 0, 0, 0, 0);
        tick(); chk("g5_busy", {31'd0, busy}, 0);
        // integer x0 never blocks; int and FP files are separate
        tick(); req(FAST, 0, 0, 0, 0, 0, 1);   iss("h0", 1, 4'b1000);
        tick(); req(FAST, 0, 4, 0, 0, 0, 2);   iss("h1", 1, 4'b1000); wbc("h1_wb", 1, FAST, 0, 0, 1);
        tick(); req(FAST, 1, 9, 4, 0, 0, 3);   iss("h2", 1, 4'b1000); wbc("h2_wb", 1, FAST, 0, 4, 2);
        tick(); wbc("h3_wb", 1, FAST, 1, 9, 3);
        tick(); chk("h4_busy", {31'd0, busy}, 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
